// File: rtl/hist_pkg.sv
// Shared definitions for the histogram sequencing controller: FSM state
// encodings, the state enum built on them, and the default RUN timeout.
package hist_pkg;

  // 3-bit state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_FLUSH = ST_FLUSH
  } hist_state_e;

  // Maximum number of RUN cycles spent waiting for hist_done
  localparam int HIST_TIMEOUT_DEFAULT = 65535;

  // Output FIFO word: {last, data}
  localparam int HIST_FIFO_W = 9;

endpackage

// File: rtl/hist_out_fifo.sv
// Two-entry synchronous FIFO carrying {last, data[7:0]} beats from the
// output RAM read port to the result stream. The head entry is presented
// combinationally on o_data/o_last. A push while full is accepted only
// when a pop happens in the same cycle.
module hist_out_fifo
  import hist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_last,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_last,
  output logic       o_full,
  output logic       o_empty
);

  logic [HIST_FIFO_W-1:0] r_mem [2];
  logic                   r_wr_ptr;
  logic                   r_rd_ptr;
  logic [1:0]             r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  assign {o_last, o_data} = r_mem[r_rd_ptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

  // Storage, pointers and occupancy; reset empties the FIFO and zeroes the head
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= {i_last, i_data};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hist_seq_ctrl.sv
// Frame sequencer beside the histogram core: starts the core on a request,
// waits (bounded) for completion, then drains the output RAM into a
// valid/ready result stream through a 2-entry FIFO.
//
// Stream handshake: a beat transfers on a rising edge where m_valid and
// m_ready are both high; once m_valid rises, m_data/m_last stay stable and
// m_valid stays high until that transfer happens.
//
// RAM reads are credit-limited: a read is issued only when the words already
// held or on their way (FIFO occupancy + read in flight - word leaving this
// cycle) number fewer than two, so the FIFO can never overflow. Counting the
// departing word keeps one beat per cycle when m_ready is held high.
module hist_seq_ctrl
  import hist_pkg::*;
#(
  parameter int W               = 64,
  parameter int H               = 64,
  parameter int TOTAL_PIXEL     = W * H,
  parameter int TOTAL_PIXEL_BIT = $clog2(W * H),
  parameter int TIMEOUT         = HIST_TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req,
  output logic                       busy,
  output logic                       err,
  output logic                       hist_start,
  input  logic                       hist_done,
  output logic [TOTAL_PIXEL_BIT-1:0] rd_addr,
  input  logic [7:0]                 rd_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [7:0]                 m_data,
  output logic                       m_last,
  output logic [2:0]                 dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [TOTAL_PIXEL_BIT-1:0] LAST_ADDR = TOTAL_PIXEL_BIT'(TOTAL_PIXEL - 1);
  localparam logic [CNT_W-1:0]           CNT_LAST  = CNT_W'(TIMEOUT - 1);

  hist_state_e r_state;
  hist_state_e w_next_state;

  logic [CNT_W-1:0]           r_cnt;
  logic [TOTAL_PIXEL_BIT-1:0] r_addr;
  logic [TOTAL_PIXEL_BIT-1:0] r_rd_addr;
  logic                       r_infl;
  logic                       r_infl_last;
  logic                       r_err;

  logic       w_issue;
  logic       w_pop;
  logic       w_addr_last;
  logic       w_timeout;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_head_last;
  logic [7:0] w_head_data;
  logic [1:0] w_occ;
  logic [2:0] w_used;

  assign w_occ       = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);
  assign w_pop       = m_valid && m_ready;
  assign w_used      = {1'b0, w_occ} + {2'b00, r_infl} - {2'b00, w_pop};
  assign w_addr_last = (r_addr == LAST_ADDR);
  assign w_issue     = (r_state == S_DRAIN) && (w_used < 3'd2);
  assign w_timeout   = (r_state == S_RUN) && (r_cnt == CNT_LAST);

  assign m_valid   = !w_fifo_empty;
  assign m_data    = w_head_data;
  assign m_last    = w_head_last && !w_fifo_empty;
  assign err       = r_err;
  assign dbg_state = r_state;

  // The address is presented in the issue cycle; otherwise the last issued one is held
  assign rd_addr = w_issue ? r_addr : r_rd_addr;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b1;
    hist_start   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (req) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        hist_start   = 1'b1;
        w_next_state = S_RUN;
      end
      S_RUN: begin
        if (hist_done) begin
          w_next_state = S_DRAIN;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_issue && w_addr_last) begin
          w_next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_pop && w_head_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // RUN cycle counter, restarted every time the core is started
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_START) begin
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Sticky timeout flag, cleared when a new request is accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && req) begin
      r_err <= 1'b0;
    end else if (w_timeout && !hist_done) begin
      r_err <= 1'b1;
    end
  end

  // Read address sequencing; stops at the last address instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_rd_addr <= '0;
    end else begin
      if (r_state == S_START) begin
        r_addr <= '0;
      end else if (w_issue && !w_addr_last) begin
        r_addr <= r_addr + TOTAL_PIXEL_BIT'(1);
      end
      if (w_issue) begin
        r_rd_addr <= r_addr;
      end
    end
  end

  // In-flight read tracking: the RAM returns data one cycle after issue
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_infl      <= w_issue;
      r_infl_last <= w_issue && w_addr_last;
    end
  end

  hist_out_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_infl),
    .i_data  (rd_data),
    .i_last  (r_infl_last),
    .i_pop   (w_pop),
    .o_data  (w_head_data),
    .o_last  (w_head_last),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_hist_seq_ctrl.sv
// Directed bench for hist_seq_ctrl with a 4x4 image, TIMEOUT=32 and an
// output RAM model holding data = addr + 1. Expected beats are queued when
// a frame is requested; a negedge monitor pops and compares every beat.
module tb_hist_seq_ctrl;

  localparam int TW  = 4;
  localparam int TH  = 4;
  localparam int TP  = TW * TH;
  localparam int TAB = $clog2(TW * TH);
  localparam int TTO = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           req;
  logic           busy;
  logic           err;
  logic           hist_start;
  logic           hist_done;
  logic [TAB-1:0] rd_addr;
  logic [7:0]     rd_data;
  logic           m_valid;
  logic           m_ready;
  logic [7:0]     m_data;
  logic           m_last;
  logic [2:0]     dbg_state;

  hist_seq_ctrl #(
    .W               (TW),
    .H               (TH),
    .TOTAL_PIXEL     (TP),
    .TOTAL_PIXEL_BIT (TAB),
    .TIMEOUT         (TTO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .busy       (busy),
    .err        (err),
    .hist_start (hist_start),
    .hist_done  (hist_done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .dbg_state  (dbg_state)
  );

  // Output RAM model: one-cycle read latency, contents addr + 1
  always @(posedge clk) rd_data <= 8'(rd_addr) + 8'd1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];

  int start_cnt     = 0;
  int start_base    = 0;
  int frame_beats   = 0;
  int first_beat_cyc = 0;
  int last_beat_cyc = 0;
  int busy_fall_cyc = 0;
  int s_cyc         = 0;
  int done_cyc      = 0;
  int rdy_mode      = 0;
  int rdy_idx       = 0;

  logic       busy_prev  = 1'b0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_expired(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (hist_start) start_cnt++;
      if (prev_stall) begin
        check("stall_valid_held", 32'(m_valid), 32'd1);
        check("stall_word_held", 32'({m_last, m_data}), 32'(prev_word));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0d last %0d, expected no beat", m_data, m_last);
        end else begin
          check("beat_word", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
        end
        if (frame_beats == 0) first_beat_cyc = cyc;
        if (m_last) last_beat_cyc = cyc;
        frame_beats++;
      end
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      busy_prev  = busy;
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_idx++;
      if (rdy_mode == 0) begin
        m_ready = 1'b1;
      end else if (rdy_mode == 1) begin
        case (rdy_idx % 4)
          0:       m_ready = 1'b1;
          1, 2:    m_ready = 1'b0;
          default: m_ready = 1'b1;
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_hist_start"}, 32'(hist_start), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_data"}, 32'(m_data), 32'd0);
    check({tag, "_m_last"}, 32'(m_last), 32'd0);
  endtask

  // Request a frame, wait for the start pulse, optionally raise hist_done
  // 10 cycles after it (pulse or held level).
  task automatic start_frame(input bit give_done, input bit done_level, input bit req_in_run);
    int n;
    frame_beats = 0;
    start_base  = start_cnt;
    if (give_done) begin
      for (int i = 0; i < TP; i++) exp_q.push_back({(i == TP - 1), 8'(i + 1)});
    end
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while (!hist_start && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!hist_start) begin
      bound_expired("wait_hist_start");
    end else begin
      s_cyc = cyc;
      check("err_clear_on_req", 32'(err), 32'd0);
    end
    if (give_done) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        req = req_in_run && (i == 2);
      end
      req       = 1'b0;
      hist_done = 1'b1;
      done_cyc  = cyc;
      if (!done_level) begin
        @(posedge clk); #1;
        hist_done = 1'b0;
      end
    end
  endtask

  // Wait for the frame to end, then check drain completeness and timing.
  task automatic finish_frame(input bit check_timing);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) bound_expired("wait_frame_end");
    hist_done = 1'b0;
    @(negedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("beats_per_frame", 32'(frame_beats), 32'(TP));
    check("single_start_pulse", 32'(start_cnt - start_base), 32'd1);
    check("busy_drop_after_last", 32'(busy_fall_cyc), 32'(last_beat_cyc + 1));
    if (check_timing) begin
      check("first_beat_latency", 32'(first_beat_cyc), 32'(done_cyc + 3));
      check("back_to_back_beats", 32'(last_beat_cyc - first_beat_cyc), 32'(TP - 1));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n     = 1'b0;
    req       = 1'b0;
    hist_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Nominal frame, hist_done pulse, ready always high
    rdy_mode = 0;
    start_frame(1'b1, 1'b0, 1'b0);
    finish_frame(1'b1);

    // Backpressure 1,0,0,1 with hist_done held as a level
    rdy_mode = 1;
    start_frame(1'b1, 1'b1, 1'b0);
    finish_frame(1'b0);
    rdy_mode = 0;

    // Timeout: hist_done never arrives
    start_frame(1'b0, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) bound_expired("wait_timeout");
    @(negedge clk); #1;
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_cycles", 32'(busy_fall_cyc), 32'(s_cyc + TTO + 1));
    check("timeout_no_beats", 32'(frame_beats), 32'd0);
    check("timeout_state_idle", 32'(dbg_state), 32'd0);

    // Next request clears err (checked at the start pulse) and runs normally
    start_frame(1'b1, 1'b0, 1'b0);
    finish_frame(1'b1);

    // hist_done while idle is ignored
    start_base = start_cnt;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      hist_done = 1'b1;
      @(negedge clk);
      check("idle_done_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    hist_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_done_no_start", 32'(start_cnt - start_base), 32'd0);

    // req during RUN is ignored
    start_frame(1'b1, 1'b0, 1'b1);
    finish_frame(1'b1);

    // Reset after the 5th beat
    start_frame(1'b1, 1'b0, 1'b0);
    n = 0;
    while (frame_beats < 5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (frame_beats < 5) bound_expired("wait_fifth_beat");
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_drain_reset");
    check("mid_drain_beats", 32'(frame_beats), 32'd5);
    start_frame(1'b1, 1'b0, 1'b0);
    finish_frame(1'b1);

    // Stall from the 15th beat for 8 cycles
    rdy_mode = 2;
    m_ready  = 1'b1;
    start_frame(1'b1, 1'b0, 1'b0);
    n = 0;
    while (frame_beats < TP - 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (frame_beats < TP - 2) bound_expired("wait_beat_14");
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("end_stall_valid", 32'(m_valid), 32'd1);
      check("end_stall_busy", 32'(busy), 32'd1);
      check("end_stall_data", 32'(m_data), 32'(TP - 1));
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    finish_frame(1'b0);
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
